// File: rtl/trace_checker_pkg.sv
// rtl/trace_checker_pkg.sv - shared state type and default sizing for trace_checker
package trace_checker_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/trace_checker_if.sv
// rtl/trace_checker_if.sv - expected-vector load and observed-sample bus for trace_checker
interface trace_checker_if
    import trace_checker_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             obs_valid;
    logic [WIDTH-1:0] obs_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        output obs_valid,
        output obs_data
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        input  obs_valid,
        input  obs_data
    );

endinterface

// File: rtl/trace_checker_buf.sv
// rtl/trace_checker_buf.sv - expected-sample register array, sync write, combinational read
module trace_checker_buf
    import trace_checker_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    // Contents survive reset and clear; the load pointer alone decides validity.
    logic [WIDTH-1:0] mem [DEPTH];

    // Single write port, one sample per cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_checker.sv
// rtl/trace_checker.sv - compares a stream of observed samples against a loaded expected vector; TRACE_CHECKER_FIRST_FAIL_EN enables first-fail capture
module trace_checker
    import trace_checker_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    trace_checker_if.slave             bus,
    input  logic                       start,
    input  logic                       clear,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [$clog2(DEPTH+1)-1:0] mismatch_count,
    output logic [$clog2(DEPTH)-1:0]   first_fail_idx,
    output logic                       first_fail_valid
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t           state;
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;
    logic [WIDTH-1:0] rd_data;
    logic             load_ready_q;
    logic             wr_en;
    logic             sample_en;
    logic             sample_miss;
    logic [CNT_W-1:0] count_next;

    // Writes land only while loading and never on a cycle that is being reset or cleared.
    assign wr_en       = (state == IDLE) && bus.load_valid && !rst && !clear;
    assign sample_en   = (state == RUN) && bus.obs_valid;
    assign sample_miss = sample_en && (bus.obs_data != rd_data);
    assign count_next  = mismatch_count + CNT_W'(sample_miss);

    assign bus.load_ready = load_ready_q;

    trace_checker_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (bus.load_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Control FSM with registered status outputs; clear shares the reset path so it beats start.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            load_ready_q   <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load_valid) begin
                        if (wr_ptr == LAST_IDX) begin
                            state        <= ARMED;
                            wr_ptr       <= '0;
                            load_ready_q <= 1'b0;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                ARMED, DONE: begin
                    if (start) begin
                        state          <= RUN;
                        rd_ptr         <= '0;
                        mismatch_count <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                    end
                end
                RUN: begin
                    if (sample_en) begin
                        mismatch_count <= count_next;
                        if (rd_ptr == LAST_IDX) begin
                            state  <= DONE;
                            rd_ptr <= '0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            pass   <= (count_next == '0);
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TRACE_CHECKER_FIRST_FAIL_EN
    // Latch the index of the first mismatch of a run; later mismatches leave it alone.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
        end else if (((state == ARMED) || (state == DONE)) && start) begin
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
        end else if (sample_miss && !first_fail_valid) begin
            first_fail_idx   <= rd_ptr;
            first_fail_valid <= 1'b1;
        end
    end
`else
    assign first_fail_idx   = '0;
    assign first_fail_valid = 1'b0;
`endif

endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 Parameter WIDTH, default 1, bit width of one observed/expected sample.
REQ-002 Parameter DEPTH, default 4, number of samples per check run; legal range 2..256.
REQ-003 Port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port load_valid  input  1  expected-vector write strobe.
REQ-006 Port load_data  input  WIDTH  expected-vector value.
REQ-007 Port load_ready  output  1  high while expected buffer accepts writes.
REQ-008 Port start  input  1  begin a check run.
REQ-009 Port clear  input  1  discard buffer contents and results, return to IDLE.
REQ-010 Port obs_valid  input  1  DUT output sample present this cycle.
REQ-011 Port obs_data  input  WIDTH  DUT output sample (e.g. nandgate c).
REQ-012 Port busy  output  1  high in RUN.
REQ-013 Port done  output  1  high in DONE.
REQ-014 Port pass  output  1  done and zero mismatches.
REQ-015 Port mismatch_count  output  $clog2(DEPTH+1)  mismatches in current/last run.
REQ-016 Port first_fail_idx  output  $clog2(DEPTH)  index of first mismatching sample.
REQ-017 Port first_fail_valid  output  1  first_fail_idx meaningful.

Function
REQ-018 States SHALL be IDLE, ARMED, RUN, DONE.
REQ-019 IDLE: load_ready=1; each load_valid writes load_data at wr_ptr, wr_ptr++.
REQ-020 Write at wr_ptr==DEPTH-1 SHALL move to ARMED next cycle; load_ready=0 from then.
REQ-021 load_valid outside IDLE SHALL be ignored, no buffer change.
REQ-022 start in IDLE (buffer partially filled) SHALL be ignored.
REQ-023 start in ARMED or DONE SHALL enter RUN next cycle: rd_ptr=0, mismatch_count=0, first_fail_valid=0.
REQ-024 RUN: each obs_valid compares obs_data with buf[rd_ptr]; inequality increments mismatch_count same edge; rd_ptr++.
REQ-025 obs_valid low in RUN SHALL hold all state (gaps allowed, no timeout).
REQ-026 Sample at rd_ptr==DEPTH-1 SHALL move to DONE next cycle; done and results valid that cycle (1-cycle latency from last sample).
REQ-027 obs_valid outside RUN SHALL be ignored.
REQ-028 DONE: done, pass, mismatch_count, first_fail_* held until start, clear, or rst.
REQ-029 start in DONE re-runs against the same buffer (no reload).
REQ-030 clear in any state SHALL go to IDLE, wr_ptr=0, all outputs to reset values; clear beats simultaneous start.
REQ-031 start and final sample in same RUN cycle: start ignored; transition to DONE.
REQ-032 mismatch_count cannot exceed DEPTH; width rule guarantees no wrap.

Reset
REQ-033 rst SHALL force IDLE, wr_ptr=0, rd_ptr=0, load_ready=1, busy=0, done=0, pass=0, mismatch_count=0, first_fail_idx=0, first_fail_valid=0.
REQ-034 Buffer contents SHALL NOT be reset; reset mid-RUN aborts run, results discarded.

Configuration
REQ-035 Macro TRACE_CHECKER_FIRST_FAIL_EN defined: first mismatch in a run captures rd_ptr into first_fail_idx and sets first_fail_valid, later mismatches do not overwrite.
REQ-036 Macro undefined: first_fail_idx and first_fail_valid ports present, tied 0; no capture logic.

Structure
REQ-037 Package trace_checker_pkg SHALL hold state enum typedef and default WIDTH/DEPTH constants.
REQ-038 Sub-module trace_checker_buf: DEPTH x WIDTH register array, one sync write port, one combinational read port.

Verification
REQ-039 Load 1,1,1,0; start; obs 1,1,1,0 on consecutive cycles -> done=1 one cycle after 4th sample, pass=1, mismatch_count=0.
REQ-040 Same load; obs 1,0,1,1 -> pass=0, mismatch_count=2, first_fail_idx=1 (macro on) / 0 with valid=0 (macro off).
REQ-041 Load 3 values then start -> stays IDLE, busy=0; 4th load -> ARMED, load_ready=0.
REQ-042 Obs with obs_valid gaps of 3 cycles -> same results as REQ-039; done only after 4th valid sample.
REQ-043 rst asserted after 2 samples in RUN -> next cycle IDLE, all outputs reset values, load_ready=1.
REQ-044 In DONE assert clear and start together -> IDLE, done=0; subsequent start ignored until 4 loads.
